// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: register address/data widths and the
// write-back helpers used by the arbiter and its load FIFO.
package mips_pkg;

    localparam int NUM_REGS       = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int WB_FIFO_DEPTH  = 2;

    typedef logic [REG_ADDR_WIDTH-1:0] regAddr_t;
    typedef logic [DATA_WIDTH-1:0]     regData_t;
    typedef logic [NUM_REGS-1:0]       regMask_t;

    typedef struct packed {
        regAddr_t addr;
        regData_t data;
    } loadEntry_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_LOAD
    } wbSource_t;

    // Register 0 is hardwired to zero, so writes to it are never performed.
    function automatic logic isZeroReg(input regAddr_t r);
        return (r == '0);
    endfunction

    function automatic regMask_t regMask(input regAddr_t r);
        regMask_t m;
        m = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order FIFO that holds accepted load results until the
// write port is free; ready depends only on the registered count.
module wb_skid_fifo
    import mips_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pushValid,
    input  loadEntry_t pushEntry,
    output logic       ready,
    input  logic       pop,
    output logic       headValid,
    output loadEntry_t headEntry
);

    loadEntry_t slots [WB_FIFO_DEPTH];
    logic [1:0] count;
    logic       rdPtr;
    logic       wrPtr;
    logic       doPush;
    logic       doPop;

    // Held low during reset so no load is accepted while the FIFO is being cleared.
    assign ready     = reset_n && (count < 2'(WB_FIFO_DEPTH));
    assign headValid = (count != 2'd0);
    assign headEntry = slots[rdPtr];
    assign doPush    = pushValid && ready;
    assign doPop     = pop && headValid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (doPush) begin
                slots[wrPtr] <= pushEntry;
                wrPtr        <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results take strict priority over
// queued loads. Define WB_SCOREBOARD_EN to build the pending-write scoreboard.
module wb_arbiter
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic [31:0] busy,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData
);

    loadEntry_t pushEntry;
    loadEntry_t headEntry;
    logic       headValid;
    logic       fifoPop;
    wbSource_t  winner;
    logic       nextRegWrite;
    regAddr_t   nextWriteAddr;
    regData_t   nextWriteData;

    assign pushEntry = '{addr: mem_addr, data: mem_data};

    wb_skid_fifo loadFifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .pushValid (mem_valid),
        .pushEntry (pushEntry),
        .ready     (mem_ready),
        .pop       (fifoPop),
        .headValid (headValid),
        .headEntry (headEntry)
    );

    always_comb begin
        winner = WB_SRC_NONE;
        if (alu_valid) begin
            winner = WB_SRC_ALU;
        end else if (headValid) begin
            winner = WB_SRC_LOAD;
        end
    end

    assign fifoPop = (winner == WB_SRC_LOAD);

    // A winning item addressed to r0 is consumed but suppresses the strobe.
    always_comb begin
        nextRegWrite  = 1'b0;
        nextWriteAddr = WriteAddr;
        nextWriteData = WriteData;
        unique case (winner)
            WB_SRC_ALU: begin
                nextRegWrite  = !isZeroReg(alu_addr);
                nextWriteAddr = alu_addr;
                nextWriteData = alu_data;
            end
            WB_SRC_LOAD: begin
                nextRegWrite  = !isZeroReg(headEntry.addr);
                nextWriteAddr = headEntry.addr;
                nextWriteData = headEntry.data;
            end
            default: begin
                nextRegWrite = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite  <= 1'b0;
            WriteAddr <= '0;
            WriteData <= '0;
        end else begin
            RegWrite  <= nextRegWrite;
            WriteAddr <= nextWriteAddr;
            WriteData <= nextWriteData;
        end
    end

`ifdef WB_SCOREBOARD_EN
    regMask_t busyReg;
    regMask_t setMask;
    regMask_t clearMask;

    // The clear uses the write being registered this edge; set wins on a tie.
    always_comb begin
        setMask   = '0;
        clearMask = '0;
        if (issue_valid && !isZeroReg(issue_addr)) begin
            setMask = regMask(issue_addr);
        end
        if (nextRegWrite) begin
            clearMask = regMask(nextWriteAddr);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busyReg <= '0;
        end else begin
            busyReg <= (busyReg & ~clearMask) | setMask;
        end
    end

    assign busy = busyReg;
`else
    logic unusedIssue;

    assign unusedIssue = ^{issue_valid, issue_addr};
    assign busy        = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes go into a time-ordered
// queue that a negedge monitor consumes whenever RegWrite is seen.
module tb_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [31:0] busy;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;

`ifdef WB_SCOREBOARD_EN
    localparam logic SB_EN = 1'b1;
`else
    localparam logic SB_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          edgeNo;
    } wbExp_t;

    wbExp_t expQ[$];
    int     edgeCount = 0;
    int     vectors = 0;
    int     miscompares = 0;

    wb_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy        (busy),
        .RegWrite    (RegWrite),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edgeCount = edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, actual, expected, edgeCount);
        end
    endtask

    // Keep the queue sorted by the edge on which each write must appear.
    task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data, input int edgeNo);
        wbExp_t e;
        int     idx;
        e.addr   = addr;
        e.data   = data;
        e.edgeNo = edgeNo;
        idx = expQ.size();
        for (int i = 0; i < expQ.size(); i++) begin
            if (expQ[i].edgeNo > edgeNo) begin
                idx = i;
                break;
            end
        end
        expQ.insert(idx, e);
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                 input logic iv, input logic [4:0] ia);
        @(negedge clock);
        alu_valid   = av;
        alu_addr    = aa;
        alu_data    = ad;
        mem_valid   = mv;
        mem_addr    = ma;
        mem_data    = md;
        issue_valid = iv;
        issue_addr  = ia;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    always @(negedge clock) begin
        if (reset_n && RegWrite) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got RegWrite=1 addr %0d data 0x%08h at edge %0d, expected no write",
                         WriteAddr, WriteData, edgeCount);
            end else begin
                wbExp_t e;
                e = expQ.pop_front();
                checkOutput("write_addr", {27'b0, WriteAddr}, {27'b0, e.addr});
                checkOutput("write_data", WriteData, e.data);
                checkOutput("write_edge", edgeCount, e.edgeNo);
            end
        end else if (reset_n && expQ.size() > 0 && expQ[0].edgeNo <= edgeCount) begin
            wbExp_t e;
            e = expQ.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_write: got RegWrite=0 at edge %0d, expected write addr %0d data 0x%08h at edge %0d",
                     edgeCount, e.addr, e.data, e.edgeNo);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion by time %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;

        // Reset state while reset_n is held low
        #12;
        checkOutput("reset_regwrite", {31'b0, RegWrite}, 32'h0);
        checkOutput("reset_writeaddr", {27'b0, WriteAddr}, 32'h0);
        checkOutput("reset_writedata", WriteData, 32'h0);
        checkOutput("reset_busy", busy, 32'h0);
        checkOutput("reset_mem_ready", {31'b0, mem_ready}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("release_mem_ready", {31'b0, mem_ready}, 32'h1);

        // ALU write appears the cycle after it is sampled
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expectWrite(5'd5, 32'hDEADBEEF, edgeCount + 1);
        idle();

        // Uncontended load: two-cycle latency
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0);
        checkOutput("load_ready_empty", {31'b0, mem_ready}, 32'h1);
        expectWrite(5'd7, 32'h11, edgeCount + 2);
        idle();
        idle();
        idle();

        // Loads queue behind a busy ALU, then drain in order
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd8, 32'h1, 1'b0, 5'd0);
        e0 = edgeCount + 1;
        expectWrite(5'd10, 32'hA0, e0);
        expectWrite(5'd8, 32'h1, e0 + 3);
        applyStimulus(1'b1, 5'd11, 32'hA1, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0);
        checkOutput("ready_one_queued", {31'b0, mem_ready}, 32'h1);
        expectWrite(5'd11, 32'hA1, e0 + 1);
        expectWrite(5'd9, 32'h2, e0 + 4);
        applyStimulus(1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'h33, 1'b0, 5'd0);
        checkOutput("ready_full", {31'b0, mem_ready}, 32'h0);
        expectWrite(5'd12, 32'hA2, e0 + 2);
        idle();
        checkOutput("ready_still_full", {31'b0, mem_ready}, 32'h0);
        idle();
        checkOutput("ready_after_pop", {31'b0, mem_ready}, 32'h1);
        idle();
        checkOutput("ready_drained", {31'b0, mem_ready}, 32'h1);
        idle();

        // Push and pop on the same edge
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h44, 1'b0, 5'd0);
        e0 = edgeCount + 1;
        expectWrite(5'd14, 32'h44, e0 + 1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'h55, 1'b0, 5'd0);
        expectWrite(5'd15, 32'h55, e0 + 2);
        idle();
        checkOutput("ready_push_pop", {31'b0, mem_ready}, 32'h1);
        idle();
        idle();

        // Destination r0 from both sources is consumed without a write
        applyStimulus(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0);
        e0 = edgeCount + 1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'h77, 1'b0, 5'd0);
        expectWrite(5'd16, 32'h77, e0 + 2);
        idle();
        idle();
        idle();
        checkOutput("hold_regwrite", {31'b0, RegWrite}, 32'h0);
        checkOutput("hold_writeaddr", {27'b0, WriteAddr}, 32'd16);
        checkOutput("hold_writedata", WriteData, 32'h77);

        // Scoreboard: set on issue, clear on write, set wins a tie
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        idle();
        checkOutput("busy_after_issue", busy, SB_EN ? 32'h8 : 32'h0);
        applyStimulus(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expectWrite(5'd3, 32'h3333, edgeCount + 1);
        checkOutput("busy_before_write", busy, SB_EN ? 32'h8 : 32'h0);
        idle();
        checkOutput("busy_after_write", busy, 32'h0);
        applyStimulus(1'b1, 5'd3, 32'h3434, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        expectWrite(5'd3, 32'h3434, edgeCount + 1);
        idle();
        checkOutput("busy_set_wins", busy, SB_EN ? 32'h8 : 32'h0);
        applyStimulus(1'b1, 5'd3, 32'h3535, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        expectWrite(5'd3, 32'h3535, edgeCount + 1);
        idle();
        checkOutput("busy_r0_never", busy, 32'h0);

        // Reset mid-operation with two loads queued
        applyStimulus(1'b1, 5'd22, 32'hC0, 1'b1, 5'd20, 32'h200, 1'b0, 5'd0);
        expectWrite(5'd22, 32'hC0, edgeCount + 1);
        applyStimulus(1'b1, 5'd23, 32'hC1, 1'b1, 5'd21, 32'h210, 1'b0, 5'd0);
        expectWrite(5'd23, 32'hC1, edgeCount + 1);
        applyStimulus(1'b1, 5'd24, 32'hC2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expectWrite(5'd24, 32'hC2, edgeCount + 1);
        @(negedge clock);
        #2;
        reset_n   = 1'b0;
        alu_valid = 1'b0;
        #1;
        checkOutput("midreset_regwrite", {31'b0, RegWrite}, 32'h0);
        checkOutput("midreset_writeaddr", {27'b0, WriteAddr}, 32'h0);
        checkOutput("midreset_writedata", WriteData, 32'h0);
        checkOutput("midreset_mem_ready", {31'b0, mem_ready}, 32'h0);
        checkOutput("midreset_busy", busy, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("midreset_release_ready", {31'b0, mem_ready}, 32'h1);
        idle();
        idle();
        idle();
        idle();

        checkOutput("queue_drained", expQ.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
